// File: rtl/paddsb_sched_pkg.sv
// Shared types and constants for the PADDSB nibble-serial scheduler.
package paddsb_pkg;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned OP_W    = NIB_W * NIBBLES;
    localparam int unsigned CNT_W   = $clog2(NIBBLES);

    localparam logic [NIB_W-1:0] SAT_POS = 4'h7;
    localparam logic [NIB_W-1:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sched_state_t;

endpackage

// File: rtl/paddsb_sched_if.sv
// Request/response bundle between the two requesters, the consumer and the scheduler.
interface paddsb_sched_if;
    import paddsb_pkg::*;

    logic            req0_vld;
    logic [OP_W-1:0] req0_a;
    logic [OP_W-1:0] req0_b;
    logic            req0_rdy;
    logic            req1_vld;
    logic [OP_W-1:0] req1_a;
    logic [OP_W-1:0] req1_b;
    logic            req1_rdy;
    logic            rsp_vld;
    logic [OP_W-1:0] rsp_sum;
    logic            rsp_id;
    logic            rsp_rdy;
    logic            busy;

    modport master (
        output req0_vld, req0_a, req0_b, req1_vld, req1_a, req1_b, rsp_rdy,
        input  req0_rdy, req1_rdy, rsp_vld, rsp_sum, rsp_id, busy
    );

    modport slave (
        input  req0_vld, req0_a, req0_b, req1_vld, req1_a, req1_b, rsp_rdy,
        output req0_rdy, req1_rdy, rsp_vld, rsp_sum, rsp_id, busy
    );

endinterface

// File: rtl/paddsb_sched_sat_add4.sv
// Combinational 4-bit carry-lookahead adder with signed saturation; carry-in is always 0.
module sat_add4
    import paddsb_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] sum,
    output logic             ovfl
);

    logic [2:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic [3:0] s;

    always_comb begin
        g    = a[2:0] & b[2:0];
        p    = a ^ b;
        c[0] = 1'b0;
        c[1] = g[0];
        c[2] = g[1] | (p[1] & g[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
        s    = p ^ c;
        // Signed overflow: like-signed operands produced an opposite-signed sum.
        ovfl = (a[3] == b[3]) && (s[3] != a[3]);
        sum  = ovfl ? (a[3] ? SAT_NEG : SAT_POS) : s;
    end

endmodule

// File: rtl/paddsb_sched.sv
// Two-requester round-robin scheduler feeding one shared 4-bit saturating lane,
// producing a 16-bit PADDSB result one nibble per cycle, LSB nibble first.
module paddsb_sched
    import paddsb_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input logic           clk,
    input logic           rst,
    paddsb_sched_if.slave bus
);

    sched_state_t     state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] nib_cnt_q, nib_cnt_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic [OP_W-1:0]  res_q, res_d;
    logic             id_q, id_d;

    logic             arb_en;
    logic             grant0;
    logic             grant1;
    logic [NIB_W-1:0] lane_a;
    logic [NIB_W-1:0] lane_b;
    logic [NIB_W-1:0] lane_sum;
    logic             lane_ovfl;

    // A new operation may start from IDLE, or from DONE as the result leaves.
    always_comb begin
        arb_en = (state_q == IDLE) || ((state_q == DONE) && bus.rsp_rdy);
        grant0 = arb_en && bus.req0_vld && (!bus.req1_vld || !rr_ptr_q);
        grant1 = arb_en && bus.req1_vld && (!bus.req0_vld || rr_ptr_q);
    end

    always_comb begin
        lane_a = a_q[nib_cnt_q*NIB_W +: NIB_W];
        lane_b = b_q[nib_cnt_q*NIB_W +: NIB_W];
    end

    sat_add4 u_lane (
        .a    (lane_a),
        .b    (lane_b),
        .sum  (lane_sum),
        .ovfl (lane_ovfl)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        nib_cnt_d = nib_cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        id_d      = id_q;

        unique case (state_q)
            IDLE: ;
            CALC: begin
                res_d[nib_cnt_q*NIB_W +: NIB_W] = lane_sum;
                if (nib_cnt_q == CNT_W'(NIBBLES - 1)) begin
                    state_d = DONE;
                end else begin
                    nib_cnt_d = nib_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant overrides the DONE->IDLE exit so back-to-back ops skip IDLE.
        if (grant0 || grant1) begin
            state_d   = CALC;
            nib_cnt_d = '0;
            a_d       = grant1 ? bus.req1_a : bus.req0_a;
            b_d       = grant1 ? bus.req1_b : bus.req0_b;
            id_d      = grant1;
            rr_ptr_d  = !grant1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= RR_INIT;
            nib_cnt_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            nib_cnt_q <= nib_cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            id_q      <= id_d;
        end
    end

    assign bus.req0_rdy = grant0;
    assign bus.req1_rdy = grant1;
    assign bus.rsp_vld  = (state_q == DONE);
    assign bus.rsp_sum  = res_q;
    assign bus.rsp_id   = id_q;
    assign bus.busy     = (state_q != IDLE);

    lane_sat_chk: assert property (@(posedge clk) disable iff (rst)
        (state_q == CALC && lane_ovfl) |-> (lane_sum == SAT_POS || lane_sum == SAT_NEG));

endmodule

// File: tb/tb_paddsb_sched.sv
// Directed-vector bench for paddsb_sched with hand-computed expected results.
module tb_paddsb_sched;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    paddsb_sched_if bus ();

    paddsb_sched #(
        .RR_INIT (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until rsp_vld, bounded so a stuck DUT still reaches the summary.
    task automatic wait_rsp(input string tag, input int exp_cycles);
        int n = 0;
        while (!bus.rsp_vld && n < 20) begin
            tick();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic accept_rsp();
        bus.rsp_rdy = 1'b1;
        tick();
        bus.rsp_rdy = 1'b0;
    endtask

    initial begin
        int seen;
        n_checks     = 0;
        n_errors     = 0;
        bus.req0_vld = 1'b0;
        bus.req0_a   = '0;
        bus.req0_b   = '0;
        bus.req1_vld = 1'b0;
        bus.req1_a   = '0;
        bus.req1_b   = '0;
        bus.rsp_rdy  = 1'b0;
        rst          = 1'b1;
        repeat (2) tick();

        check("rst_rsp_vld", bus.rsp_vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rsp_sum", bus.rsp_sum, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        rst = 1'b0;
        tick();

        // 1: simple add from requester 0
        bus.req0_a   = 16'h1234;
        bus.req0_b   = 16'h1111;
        bus.req0_vld = 1'b1;
        #1;
        check("t1_rdy0", bus.req0_rdy, 1);
        check("t1_rdy1", bus.req1_rdy, 0);
        tick();
        bus.req0_vld = 1'b0;
        check("t1_busy", bus.busy, 1);
        check("t1_calc_vld", bus.rsp_vld, 0);
        wait_rsp("t1_latency", 4);
        check("t1_sum", bus.rsp_sum, 16'h2345);
        check("t1_id", bus.rsp_id, 0);
        accept_rsp();
        check("t1_idle_busy", bus.busy, 0);
        check("t1_idle_vld", bus.rsp_vld, 0);
        check("t1_idle_sum_hold", bus.rsp_sum, 16'h2345);

        // 2: saturation in both directions from requester 1
        bus.req1_a   = 16'h7F81;
        bus.req1_b   = 16'h118F;
        bus.req1_vld = 1'b1;
        #1;
        check("t2_rdy1", bus.req1_rdy, 1);
        check("t2_rdy0", bus.req0_rdy, 0);
        tick();
        bus.req1_vld = 1'b0;
        wait_rsp("t2_latency", 4);
        check("t2_sum", bus.rsp_sum, 16'h7080);
        check("t2_id", bus.rsp_id, 1);
        accept_rsp();

        // 3: both requesters from reset, RR_INIT=0 -> req0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0_a   = 16'h0001;
        bus.req0_b   = 16'h0001;
        bus.req1_a   = 16'h8000;
        bus.req1_b   = 16'h8000;
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;
        #1;
        check("t3_rdy0", bus.req0_rdy, 1);
        check("t3_rdy1", bus.req1_rdy, 0);
        tick();
        bus.req0_vld = 1'b0;
        check("t3_calc_rdy1", bus.req1_rdy, 0);
        wait_rsp("t3_latency", 4);
        check("t3_sum", bus.rsp_sum, 16'h0002);
        check("t3_id", bus.rsp_id, 0);

        // 4: backpressure in DONE with req1 still pending
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_vld", bus.rsp_vld, 1);
            check("t4_sum", bus.rsp_sum, 16'h0002);
            check("t4_id", bus.rsp_id, 0);
            check("t4_rdy0", bus.req0_rdy, 0);
            check("t4_rdy1", bus.req1_rdy, 0);
            check("t4_busy", bus.busy, 1);
        end

        // 5: release result; pending req1 granted in the same cycle
        bus.rsp_rdy = 1'b1;
        #1;
        check("t5_rdy1", bus.req1_rdy, 1);
        check("t5_rdy0", bus.req0_rdy, 0);
        tick();
        bus.req1_vld = 1'b0;
        bus.rsp_rdy  = 1'b0;
        check("t5_vld_drop", bus.rsp_vld, 0);
        check("t5_busy", bus.busy, 1);
        wait_rsp("t5_b2b_after_hs", 4);
        check("t5_sum", bus.rsp_sum, 16'h8000);
        check("t5_id", bus.rsp_id, 1);
        accept_rsp();

        // 6: async reset mid-operation (nib_cnt=2)
        bus.req0_a   = 16'h1111;
        bus.req0_b   = 16'h1111;
        bus.req0_vld = 1'b1;
        #1;
        check("t6_rdy0", bus.req0_rdy, 1);
        tick();
        bus.req0_vld = 1'b0;
        tick();
        tick();
        #2;
        check("t6_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_vld", bus.rsp_vld, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_sum", bus.rsp_sum, 0);
        tick();
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (bus.rsp_vld) seen++;
        end
        check("t6_no_rsp", seen, 0);
        check("t6_idle_busy", bus.busy, 0);

        // 7: round-robin pointer flips after a single grant to req0
        bus.req0_a   = 16'h3456;
        bus.req0_b   = 16'h4321;
        bus.req0_vld = 1'b1;
        #1;
        check("t7_rdy0", bus.req0_rdy, 1);
        tick();
        bus.req0_vld = 1'b0;
        wait_rsp("t7_latency", 4);
        check("t7_sum", bus.rsp_sum, 16'h7777);
        check("t7_id", bus.rsp_id, 0);
        accept_rsp();
        bus.req0_a   = 16'hFFFF;
        bus.req0_b   = 16'hFFFF;
        bus.req1_a   = 16'h4321;
        bus.req1_b   = 16'h4000;
        bus.req0_vld = 1'b1;
        bus.req1_vld = 1'b1;
        #1;
        check("t7_rr_rdy1", bus.req1_rdy, 1);
        check("t7_rr_rdy0", bus.req0_rdy, 0);
        tick();
        bus.req0_vld = 1'b0;
        bus.req1_vld = 1'b0;
        wait_rsp("t7_rr_latency", 4);
        check("t7_rr_sum", bus.rsp_sum, 16'h7321);
        check("t7_rr_id", bus.rsp_id, 1);
        accept_rsp();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
